shift_piso_tx: RTL and testbench
================================

// Module: shift_piso_tx
// PURPOSE
//  Parallel-in serial-out transmitter; mirror of the Shift_SIPO serial receiver in the LED effect path.
//  Accepts a word via valid/ready handshake, then emits it one bit per clk on s_out.
//  Bit order follows lr so a Shift_SIPO with the same lr, enabled by s_valid, reassembles d_in exactly.
//  Bit count, busy and done are explicit; an optional parity bit is appended per frame.
// PARAMETERS
//  WIDTH   8   data word width in bits (>=2)
// PORTS
//  clk      in   1      system clock, all logic on rising edge
//  reset    in   1      synchronous, active-high reset
//  d_in     in   WIDTH  parallel word to transmit
//  d_valid  in   1      d_in valid; accepted when d_valid && d_ready at a rising clk
//  d_ready  out  1      block can accept a word (high only in IDLE)
//  lr       in   1      1: LSB first (right shift); 0: MSB first (left shift); sampled at accept
//  s_out    out  1      serial data bit, registered
//  s_valid  out  1      s_out carries a frame bit this cycle
//  busy     out  1      high in SHIFT/PARITY states
//  done     out  1      one-cycle pulse after the last frame bit
// BEHAVIOUR
//  - Reset: synchronous, active-high. Only the clk edge with reset=1 clears state.
//    On that edge: state=IDLE; shift reg, bit counter and lr_q cleared; s_out=0, s_valid=0, busy=0, done=0; d_ready=1.
//  - Reset mid-frame aborts the frame. No done pulse; remaining bits are dropped.
//  - FSM states: IDLE, SHIFT, PARITY (PARITY only with the macro), DONE.
//  - IDLE: d_ready=1, s_out=0, s_valid=0.
//    On accept (edge k): shift reg<=d_in, lr_q<=lr, cnt<=0, go to SHIFT.
//  - SHIFT: present the first bit in cycle k+1, registered on edge k.
//    s_out = lr_q ? reg[0] : reg[WIDTH-1]; s_valid=1; busy=1.
//    Each edge: lr_q=1 shifts reg right, lr_q=0 shifts reg left; zero fill; cnt<=cnt+1.
//    Bit i (0-based) is on s_out in cycle k+1+i. Counter width $clog2(WIDTH+1); no wrap within a frame.
//    After bit WIDTH-1 (cnt==WIDTH-1): go to PARITY if enabled, else DONE.
//  - DONE: one cycle. done=1, s_valid=0, s_out=0, busy=0, d_ready=0. Next state IDLE.
//  - Throughput: WIDTH+2 cycles per word without parity; WIDTH+3 with parity.
//  - d_valid while not IDLE: ignored, because d_ready=0. d_in and lr changes mid-frame have no effect.
//  - d_valid held high in IDLE: the word is accepted on the first IDLE edge, so the producer must drop
//    or update d_valid after the accept.
// CONFIGURATION
//  SHIFT_PISO_PARITY_EN defined:
//    After the data bits, PARITY state lasts one cycle.
//    s_out = even parity (XOR) of the accepted word, s_valid=1, busy=1.
//    The receiver must count WIDTH+1 bits.
//  SHIFT_PISO_PARITY_EN undefined:
//    No PARITY state and no parity logic. The frame is exactly WIDTH bits.
// TESTING
//  1 reset=1 for 2 clks, mid-idle -> s_out=0, s_valid=0, busy=0, done=0, d_ready=1.
//  2 WIDTH=8, lr=1, d_in=8'hC4 accepted at edge 0 -> s_out in cycles 1..8 = 0,0,1,0,0,0,1,1;
//    done=1 in cycle 9; d_ready=1 in cycle 10.
//  3 lr=0, d_in=8'hC4 -> s_out cycles 1..8 = 1,1,0,0,0,1,0,0.
//  4 Loopback: s_out->s_in, s_valid gating the SIPO clock enable, same lr, words 8'h5A/8'h81
//    -> SIPO q_out equals d_in when done pulses. Both lr values.
//  5 d_valid=1 with d_in=8'hFF during busy -> ignored, frame unchanged.
//    reset at cycle 4 of a frame -> next cycle idle, no done pulse.
//  6 SHIFT_PISO_PARITY_EN, lr=1, d_in=8'hC4 -> 8 data bits, then s_out=1 in cycle 9; done in cycle 10.

Source files
------------

// File: rtl/shift_piso_tx.sv
// Parallel-in serial-out transmitter: accepts a WIDTH-bit word, then shifts it out one bit per clk.
// Latency: first bit on s_out the cycle after accept; WIDTH+2 cycles per word (WIDTH+3 with parity).
// Backpressure: d_ready is high only in IDLE, so a word offered mid-frame waits until the frame ends.
// Optional feature macro: SHIFT_PISO_PARITY_EN appends an even-parity bit after the data bits.
module shift_piso_tx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_in,
  input  logic             d_valid,
  output logic             d_ready,
  input  logic             lr,
  output logic             s_out,
  output logic             s_valid,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

`ifdef SHIFT_PISO_PARITY_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2,
    ST_DONE   = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_DONE   = 2'd3
  } state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             lr_q, lr_d;
  logic             s_out_q, s_out_d;
  logic             s_valid_q, s_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] shifted;
`ifdef SHIFT_PISO_PARITY_EN
  logic             parity_q, parity_d;
`endif

  assign d_ready = (state_q == ST_IDLE);
  assign s_out   = s_out_q;
  assign s_valid = s_valid_q;
  assign busy    = busy_q;
  assign done    = done_q;

  // Next-state and next-output logic; outputs are registered so each bit is set up one edge ahead.
  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    cnt_d     = cnt_q;
    lr_d      = lr_q;
    s_out_d   = 1'b0;
    s_valid_d = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    shifted   = lr_q ? {1'b0, sreg_q[WIDTH-1:1]} : {sreg_q[WIDTH-2:0], 1'b0};
`ifdef SHIFT_PISO_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (d_valid) begin
          sreg_d    = d_in;
          lr_d      = lr;
          cnt_d     = '0;
          s_out_d   = lr ? d_in[0] : d_in[WIDTH-1];
          s_valid_d = 1'b1;
          busy_d    = 1'b1;
          state_d   = ST_SHIFT;
`ifdef SHIFT_PISO_PARITY_EN
          parity_d  = ^d_in;
`endif
        end
      end
      ST_SHIFT: begin
        sreg_d = shifted;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
`ifdef SHIFT_PISO_PARITY_EN
          s_out_d   = parity_q;
          s_valid_d = 1'b1;
          busy_d    = 1'b1;
          state_d   = ST_PARITY;
`else
          done_d    = 1'b1;
          state_d   = ST_DONE;
`endif
        end else begin
          s_out_d   = lr_q ? shifted[0] : shifted[WIDTH-1];
          s_valid_d = 1'b1;
          busy_d    = 1'b1;
        end
      end
`ifdef SHIFT_PISO_PARITY_EN
      ST_PARITY: begin
        done_d  = 1'b1;
        state_d = ST_DONE;
      end
`endif
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register with synchronous reset; reset mid-frame drops the frame without a done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      sreg_q    <= '0;
      cnt_q     <= '0;
      lr_q      <= 1'b0;
      s_out_q   <= 1'b0;
      s_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef SHIFT_PISO_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      cnt_q     <= cnt_d;
      lr_q      <= lr_d;
      s_out_q   <= s_out_d;
      s_valid_q <= s_valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef SHIFT_PISO_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_shift_piso_tx.sv
// Randomized scoreboard bench for shift_piso_tx: expected frame bits queued at accept, popped by a monitor.
// Monitor samples on the falling edge; stimulus drives 1 time unit after the rising edge.
// A receiver model reassembles each frame at done and compares it with the accepted word.
module tb_shift_piso_tx;
  localparam int W = 8;
`ifdef SHIFT_PISO_PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif

  typedef struct {
    logic [W-1:0] w;
    logic         l;
  } frame_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] d_in = '0;
  logic         d_valid = 1'b0;
  logic         lr = 1'b0;
  logic         d_ready, s_out, s_valid, busy, done;

  int     total = 0;
  int     bad = 0;
  int     abort_cnt = 0;
  logic   bit_q[$];
  frame_t frm_q[$];

  shift_piso_tx #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .d_in(d_in), .d_valid(d_valid), .d_ready(d_ready),
    .lr(lr), .s_out(s_out), .s_valid(s_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: frame bit i is word[i] (LSB first) or word[W-1-i] (MSB first), then the XOR parity.
  task automatic push_frame(input logic [W-1:0] w, input logic l);
    frame_t f;
    for (int i = 0; i < W; i++) bit_q.push_back(l ? w[i] : w[W-1-i]);
`ifdef SHIFT_PISO_PARITY_EN
    bit_q.push_back(^w);
`endif
    f.w = w;
    f.l = l;
    frm_q.push_back(f);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (d_ready !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) check("ready_timeout", 32'(d_ready), 32'd1);
  endtask

  // Offer a word; optionally keep d_valid high with a different word while the frame is in flight.
  task automatic send(input logic [W-1:0] w, input logic l, input bit hold);
    wait_ready();
    d_in = w; lr = l; d_valid = 1'b1;
    @(posedge clk); #1;
    push_frame(w, l);
    if (hold) begin
      d_in = 8'hFF; lr = ~l;
      repeat (W - 1) begin @(posedge clk); #1; end
    end
    d_valid = 1'b0;
    d_in = W'($urandom);
  endtask

  // Monitor: compare every presented bit against the queue; at done reassemble the word.
  initial begin : monitor
    int   rx_n = 0;
    int   seen_abort = 0;
    bit   chk_idle = 0;
    logic rx[FL];
    logic exp_b;
    logic [W-1:0] word;
    frame_t f;
    forever begin
      @(negedge clk);
      if (abort_cnt != seen_abort) begin
        seen_abort = abort_cnt;
        rx_n = 0;
        chk_idle = 0;
      end
      if (!reset) begin
        if (chk_idle) begin
          check("ready_after_done", 32'(d_ready), 32'd1);
          chk_idle = 0;
        end
        if (s_valid === 1'b1) begin
          check("busy_with_bit", 32'(busy), 32'd1);
          check("ready_while_busy", 32'(d_ready), 32'd0);
          if (bit_q.size() == 0) begin
            check("unexpected_bit", 32'd1, 32'd0);
          end else begin
            exp_b = bit_q.pop_front();
            check("serial_bit", 32'(s_out), 32'(exp_b));
            if (rx_n < FL) rx[rx_n] = s_out;
            rx_n++;
          end
        end else begin
          check("idle_sout", 32'(s_out), 32'd0);
        end
        if (done === 1'b1) begin
          check("done_busy", 32'(busy), 32'd0);
          if (frm_q.size() == 0) begin
            check("spurious_done", 32'd1, 32'd0);
          end else begin
            f = frm_q.pop_front();
            check("frame_len", 32'(rx_n), 32'(FL));
            word = '0;
            for (int i = 0; i < W; i++) word[f.l ? i : W-1-i] = rx[i];
            check("loopback_word", 32'(word), 32'(f.w));
          end
          rx_n = 0;
          chk_idle = 1;
        end
      end
    end
  end

  initial begin : stim
    int n;
    // Reset held two clocks in idle.
    reset = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    check("rst_sout", 32'(s_out), 32'd0);
    check("rst_svalid", 32'(s_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ready", 32'(d_ready), 32'd1);
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed words: both bit orders, loopback words, busy-time injection.
    send(8'hC4, 1'b1, 1'b0);
    send(8'hC4, 1'b0, 1'b0);
    send(8'h5A, 1'b1, 1'b0);
    send(8'h5A, 1'b0, 1'b0);
    send(8'h81, 1'b1, 1'b0);
    send(8'h81, 1'b0, 1'b0);
    send(8'h3C, 1'b1, 1'b1);
    send(8'h00, 1'b0, 1'b1);

    // Reset in cycle 4 of a frame: frame dropped, idle the next cycle, no done pulse.
    wait_ready();
    d_in = 8'hA7; lr = 1'b1; d_valid = 1'b1;
    @(posedge clk); #1;
    push_frame(8'hA7, 1'b1);
    d_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    bit_q.delete();
    frm_q.delete();
    abort_cnt++;
    check("abort_svalid", 32'(s_valid), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_ready", 32'(d_ready), 32'd1);
    repeat (W + 4) begin @(posedge clk); #1; end

    // Random words, bit orders, busy injection and idle gaps.
    for (int k = 0; k < 40; k++) begin
      send(W'($urandom), 1'($urandom), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
    end

    n = 0;
    while ((bit_q.size() != 0 || frm_q.size() != 0) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain", 32'(bit_q.size() + frm_q.size()), 32'd0);
    repeat (2) begin @(posedge clk); #1; end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
